fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequencer for the instruction-fetch stage. Drives the PC enable, NOP-inject (stall), redirect enable/target and IF/ID enable.
//  Arbitrates the fetch stage between three requesters: EX redirects, ID load-use hazards and an external halt/debug request.
//  Handles the post-reset boot wait and pipeline drain on halt. Sits between the hazard/EX logic and the IF stage.
// PARAMETERS
//  ADDR_WIDTH    `MEM_ADDR_WIDTH  width of PC / redirect target
//  BOOT_WAIT     2                cycles after reset release before the first fetch (>=1)
//  DRAIN_CYCLES  4                NOP cycles injected before halted asserts; equals pipeline depth behind IF (>=1)
// PORTS
//  clk              in   1           clock, rising edge
//  rst_n            in   1           reset, asynchronous, active-low
//  redirect_valid   in   1           EX resolved a taken branch/jump this cycle
//  redirect_tgt     in   ADDR_WIDTH  redirect target address
//  load_use_hazard  in   1           ID needs a one-cycle hold
//  halt_req         in   1           level: request pipeline halt; deassert to resume
//  step_req         in   1           single-step pulse (used only with FETCH_CTRL_SINGLE_STEP_EN)
//  pc_en            out  1           PC update enable
//  stall_en         out  1           IF outputs NOP instead of the fetched instruction
//  ifid_en          out  1           IF/ID register load enable
//  jmp_bch_en       out  1           PC next-address mux selects jmp_bch_tgt
//  jmp_bch_tgt      out  ADDR_WIDTH  redirect target (combinational pass of redirect_tgt)
//  flush_id         out  1           squash the instruction currently in ID
//  halted           out  1           pipeline drained and frozen
// BEHAVIOUR
//  - States: BOOT, RUN, DRAIN, HALTED (+STEP with macro). Outputs decode combinationally from state and inputs; cnt is a down-counter.
//  - Reset (async, immediate, also mid-operation): state=BOOT, cnt=BOOT_WAIT.
//    Outputs: pc_en=0, stall_en=1, ifid_en=1, jmp_bch_en=0, jmp_bch_tgt=0, flush_id=0, halted=0.
//  - BOOT: reset outputs held; all inputs ignored. cnt decrements each cycle; at cnt==1 -> RUN. First pc_en=1 is BOOT_WAIT cycles after release.
//  - Redirect (RUN, DRAIN, STEP): redirect_valid=1 gives, same cycle: jmp_bch_en=1, jmp_bch_tgt=redirect_tgt, pc_en=1, stall_en=1, ifid_en=1, flush_id=1.
//    Redirect has highest priority; it overrides load_use_hazard and halt_req. In DRAIN it reloads cnt=DRAIN_CYCLES.
//  - RUN: priority redirect > halt_req > load_use_hazard.
//    halt_req: -> DRAIN, cnt=DRAIN_CYCLES; pc_en=0 this cycle.
//    load_use_hazard: pc_en=0, ifid_en=0, stall_en=0 for exactly the cycles it is high.
//    Otherwise: pc_en=1, stall_en=0, ifid_en=1.
//  - DRAIN: pc_en=0, stall_en=1, ifid_en=1; cnt decrements; at cnt==1 -> HALTED.
//    load_use_hazard (no redirect): ifid_en=0 and cnt holds.
//    halt_req=0: -> RUN next cycle (abort); halted never asserts.
//  - HALTED: pc_en=0, stall_en=1, halted=1. halt_req=0 -> RUN; halted=0 and pc_en=1 next cycle.
//    redirect_valid here is illegal (pipeline empty): ignore and flag with a simulation assertion.
//  - jmp_bch_en=0 everywhere except a redirect cycle; jmp_bch_tgt=0 when jmp_bch_en=0.
//  - cnt width $clog2(max(BOOT_WAIT,DRAIN_CYCLES)+1); never underflows (min reload 1).
// CONFIGURATION
//  FETCH_CTRL_SINGLE_STEP_EN defined:
//    step_req=1 in HALTED with halt_req=1 -> STEP for one cycle: pc_en=1, stall_en=0, ifid_en=1, halted=0.
//    STEP then -> DRAIN with cnt=DRAIN_CYCLES.
//  Not defined: step_req ignored, STEP state absent.
// STRUCTURE
//  - constants.vh: state encodings (FC_BOOT/FC_RUN/FC_DRAIN/FC_HALTED/FC_STEP) and default BOOT_WAIT/DRAIN_CYCLES.
//  - One sub-module: fc_down_counter (load, dec, hold, is_one flag), shared by BOOT and DRAIN.
//  - Everything else lives in a single state register plus the output decode.
// TESTING
//  1. Release rst_n with BOOT_WAIT=2 -> pc_en=0, stall_en=1 for 2 cycles; pc_en=1, stall_en=0 on 3rd cycle.
//  2. redirect_valid=1, tgt=0x40, load_use_hazard=1 same cycle -> jmp_bch_en=1, tgt=0x40, pc_en=1, flush_id=1, stall_en=1; next cycle normal RUN.
//  3. load_use_hazard high 1 cycle in RUN -> pc_en=0, ifid_en=0 that cycle only; pc_en=1 after.
//  4. halt_req held, DRAIN_CYCLES=4 -> halted rises 4 cycles after DRAIN entry.
//     Redirect in 2nd drain cycle -> halted rises 4 cycles after the redirect.
//  5. halt_req dropped in HALTED -> halted=0, pc_en=1 next cycle. Dropped mid-DRAIN -> RUN next cycle, halted stays 0.
//     rst_n low mid-DRAIN -> BOOT outputs immediately.
//  6. Macro on, HALTED, step_req pulse -> one cycle pc_en=1, stall_en=0; halted again 4 cycles later. Macro off -> no change.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: state encoding, default timing and counter sizing for fetch_ctrl
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
package fetch_ctrl_pkg;
  typedef enum logic [2:0] {
    FC_BOOT   = 3'd0,
    FC_RUN    = 3'd1,
    FC_DRAIN  = 3'd2,
    FC_HALTED = 3'd3
`ifdef FETCH_CTRL_SINGLE_STEP_EN
    ,
    FC_STEP   = 3'd4
`endif
  } fc_state_t;
  localparam int FC_BOOT_WAIT    = 2;
  localparam int FC_DRAIN_CYCLES = 4;
  localparam int FC_ADDR_WIDTH   = `MEM_ADDR_WIDTH;
  function automatic int fc_cnt_width(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/fc_down_counter.sv
// fc_down_counter: loadable down-counter with hold and is_one flag, shared by boot wait and drain
module fc_down_counter
    import fetch_ctrl_pkg::*;
#(
    parameter int           W       = 3,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         is_one
);

    // load wins over decrement; with neither asserted the count holds; never wraps below zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= RST_VAL;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign is_one = cnt == W'(1);

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer arbitrating redirect, load-use hold and halt/drain (FETCH_CTRL_SINGLE_STEP_EN enables single-step)
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = FC_ADDR_WIDTH,
    parameter int BOOT_WAIT    = FC_BOOT_WAIT,
    parameter int DRAIN_CYCLES = FC_DRAIN_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_tgt,
    input  logic                  load_use_hazard,
    input  logic                  halt_req,
    input  logic                  step_req,
    output logic                  pc_en,
    output logic                  stall_en,
    output logic                  ifid_en,
    output logic                  jmp_bch_en,
    output logic [ADDR_WIDTH-1:0] jmp_bch_tgt,
    output logic                  flush_id,
    output logic                  halted
);

    localparam int            CW       = fc_cnt_width(BOOT_WAIT, DRAIN_CYCLES);
    localparam logic [CW-1:0] BOOT_LD  = CW'(BOOT_WAIT);
    localparam logic [CW-1:0] DRAIN_LD = CW'(DRAIN_CYCLES);

    fc_state_t     state, state_nxt;
    logic          cnt_load, cnt_dec, cnt_one, redir_ok;
    logic [CW-1:0] cnt;

`ifndef FETCH_CTRL_SINGLE_STEP_EN
    logic unused_step_req;
    assign unused_step_req = step_req;
`endif

    fc_down_counter #(.W(CW), .RST_VAL(BOOT_LD)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (DRAIN_LD),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .is_one   (cnt_one)
    );

    // state register; reset lands in BOOT immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FC_BOOT;
        else
            state <= state_nxt;
    end

    // next state, counter control and output decode; a legal redirect overrides every other output
    always_comb begin
        state_nxt  = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        pc_en      = 1'b0;
        stall_en   = 1'b1;
        ifid_en    = 1'b1;
        jmp_bch_en = 1'b0;
        flush_id   = 1'b0;
        halted     = 1'b0;
        redir_ok   = 1'b0;
        case (state)
            FC_BOOT: begin
                cnt_dec = 1'b1;
                if (cnt_one)
                    state_nxt = FC_RUN;
            end
            FC_RUN: begin
                redir_ok = redirect_valid;
                if (redirect_valid) begin
                end else if (halt_req) begin
                    state_nxt = FC_DRAIN;
                    cnt_load  = 1'b1;
                end else if (load_use_hazard) begin
                    stall_en = 1'b0;
                    ifid_en  = 1'b0;
                end else begin
                    pc_en    = 1'b1;
                    stall_en = 1'b0;
                end
            end
            FC_DRAIN: begin
                redir_ok = redirect_valid;
                if (redirect_valid) begin
                    cnt_load  = 1'b1;
                    state_nxt = halt_req ? FC_DRAIN : FC_RUN;
                end else if (!halt_req)
                    state_nxt = FC_RUN;
                else if (load_use_hazard)
                    ifid_en = 1'b0;
                else if (cnt_one)
                    state_nxt = FC_HALTED;
                else
                    cnt_dec = 1'b1;
            end
            FC_HALTED: begin
                halted = 1'b1;
                if (!halt_req)
                    state_nxt = FC_RUN;
`ifdef FETCH_CTRL_SINGLE_STEP_EN
                else if (step_req)
                    state_nxt = FC_STEP;
`endif
            end
`ifdef FETCH_CTRL_SINGLE_STEP_EN
            FC_STEP: begin
                redir_ok  = redirect_valid;
                cnt_load  = 1'b1;
                state_nxt = FC_DRAIN;
                pc_en     = 1'b1;
                stall_en  = 1'b0;
            end
`endif
            default: state_nxt = FC_BOOT;
        endcase
        if (redir_ok) begin
            pc_en      = 1'b1;
            stall_en   = 1'b1;
            ifid_en    = 1'b1;
            jmp_bch_en = 1'b1;
            flush_id   = 1'b1;
        end
    end

    assign jmp_bch_tgt = jmp_bch_en ? redirect_tgt : '0;

    // a redirect while halted means EX produced a result from an empty pipeline; it is ignored
    always_ff @(posedge clk) begin
        if (rst_n && state == FC_HALTED)
            assert (!redirect_valid) else $error("fetch_ctrl: redirect_valid while halted");
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

    localparam logic [5:0] BOOTO = 6'b011000;
    localparam logic [5:0] DRNO  = 6'b011000;
    localparam logic [5:0] RUNO  = 6'b101000;
    localparam logic [5:0] REDO  = 6'b111110;
    localparam logic [5:0] LUO   = 6'b000000;
    localparam logic [5:0] DRLU  = 6'b010000;
    localparam logic [5:0] HLTO  = 6'b011001;
    localparam logic [5:0] STPO  = 6'b101000;

    typedef struct {
        logic [5:0]  b;
        logic [31:0] t;
        string       n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_tgt = '0;
    logic        load_use_hazard = 1'b0;
    logic        halt_req = 1'b0;
    logic        step_req = 1'b0;
    logic        pc_en, stall_en, ifid_en, jmp_bch_en, flush_id, halted;
    logic [31:0] jmp_bch_tgt;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.ADDR_WIDTH(32), .BOOT_WAIT(2), .DRAIN_CYCLES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_tgt    (redirect_tgt),
        .load_use_hazard (load_use_hazard),
        .halt_req        (halt_req),
        .step_req        (step_req),
        .pc_en           (pc_en),
        .stall_en        (stall_en),
        .ifid_en         (ifid_en),
        .jmp_bch_en      (jmp_bch_en),
        .jmp_bch_tgt     (jmp_bch_tgt),
        .flush_id        (flush_id),
        .halted          (halted)
    );

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({pc_en, stall_en, ifid_en, jmp_bch_en, flush_id, halted, jmp_bch_tgt} !== {e.b, e.t}) begin
                errors++;
                $display("FAIL %s: got pc/stall/ifid/jmp/flush/halted=%b tgt=%h, expected %b tgt=%h",
                         e.n, {pc_en, stall_en, ifid_en, jmp_bch_en, flush_id, halted}, jmp_bch_tgt, e.b, e.t);
            end
        end
    end

    task automatic cyc(input logic rv, input logic [31:0] tg, input logic lu, input logic hr, input logic sr,
                       input logic [5:0] eb, input logic [31:0] et, input string nm);
        exp_t x;
        redirect_valid  = rv;
        redirect_tgt    = tg;
        load_use_hazard = lu;
        halt_req        = hr;
        step_req        = sr;
        x.b = eb;
        x.t = et;
        x.n = nm;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 0, BOOTO, 0, "reset0");
        cyc(1, 32'h99, 1, 1, 0, BOOTO, 0, "reset1");
        rst_n = 1'b1;
        cyc(1, 32'h44, 1, 1, 0, BOOTO, 0, "boot0_ignore");
        cyc(0, 0, 0, 0, 0, BOOTO, 0, "boot1");
        cyc(0, 0, 0, 0, 0, RUNO, 0, "first_fetch");
        cyc(1, 32'h40, 1, 0, 0, REDO, 32'h40, "redirect_over_lu");
        cyc(0, 0, 0, 0, 0, RUNO, 0, "after_redirect");
        cyc(0, 0, 1, 0, 0, LUO, 0, "load_use");
        cyc(0, 0, 0, 0, 0, RUNO, 0, "after_load_use");
        cyc(0, 0, 0, 1, 0, DRNO, 0, "halt_enter");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, DRNO, 0, $sformatf("drain%0d", i));
        cyc(0, 0, 0, 1, 0, HLTO, 0, "halted_rise");
        cyc(0, 0, 0, 1, 0, HLTO, 0, "halted_hold");
        cyc(0, 0, 0, 0, 0, HLTO, 0, "halt_release");
        cyc(0, 0, 0, 0, 0, RUNO, 0, "resume");
        cyc(0, 0, 0, 1, 0, DRNO, 0, "halt_enter2");
        cyc(0, 0, 0, 1, 0, DRNO, 0, "drain2_0");
        cyc(1, 32'h80, 0, 1, 0, REDO, 32'h80, "drain_redirect");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, DRNO, 0, $sformatf("redrain%0d", i));
        cyc(0, 0, 0, 1, 0, HLTO, 0, "halted_after_redirect");
        cyc(0, 0, 0, 0, 0, HLTO, 0, "halt_release2");
        cyc(0, 0, 0, 0, 0, RUNO, 0, "resume2");
        cyc(0, 0, 0, 1, 0, DRNO, 0, "halt_enter3");
        cyc(0, 0, 1, 1, 0, DRLU, 0, "drain_load_use");
        cyc(0, 0, 0, 1, 0, DRNO, 0, "drain3_1");
        cyc(0, 0, 0, 0, 0, DRNO, 0, "drain_abort");
        cyc(0, 0, 0, 0, 0, RUNO, 0, "abort_run");
        cyc(0, 0, 0, 1, 0, DRNO, 0, "halt_enter4");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, DRNO, 0, $sformatf("drain4_%0d", i));
        cyc(0, 0, 0, 1, 0, HLTO, 0, "halted4");
        cyc(0, 0, 0, 1, 1, HLTO, 0, "step_pulse");
`ifdef FETCH_CTRL_SINGLE_STEP_EN
        cyc(0, 0, 0, 1, 0, STPO, 0, "step_cycle");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, DRNO, 0, $sformatf("step_drain%0d", i));
`else
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, HLTO, 0, $sformatf("step_ignored%0d", i));
`endif
        cyc(0, 0, 0, 1, 0, HLTO, 0, "halted_after_step");
        cyc(0, 0, 0, 0, 0, HLTO, 0, "halt_release3");
        cyc(0, 0, 0, 0, 0, RUNO, 0, "resume3");
        cyc(0, 0, 0, 1, 0, DRNO, 0, "halt_enter5");
        cyc(0, 0, 0, 1, 0, DRNO, 0, "drain5_0");
        rst_n = 1'b0;
        cyc(1, 32'h123, 0, 1, 0, BOOTO, 0, "async_reset_mid_drain");
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, BOOTO, 0, "reboot0");
        cyc(0, 0, 0, 0, 0, BOOTO, 0, "reboot1");
        cyc(0, 0, 0, 0, 0, RUNO, 0, "refetch");
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
